// File: rtl/cpu_ctrl_pkg.sv
// Shared FSM state encoding and debug command codes for the CPU run controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_HALT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_HALT  = 2'b10,
    CMD_STEP  = 2'b11
  } cmd_e;

  // States in which the CPU clock enable is raised.
  function automatic logic is_exec(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/run_ctrl_counter.sv
// Step down-counter and saturating executed-cycle counter used by cpu_run_ctrl.
module run_ctrl_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic             step_last_o,
  output logic [CNT_W-1:0] exec_cnt_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] exec_q, exec_d;

  // Next counter values; a zero step argument still runs one instruction.
  always_comb begin
    if (load_i) begin
      step_d = (load_val_i == '0) ? ONE : load_val_i;
    end else if (dec_i && (step_q != '0)) begin
      step_d = step_q - ONE;
    end else begin
      step_d = step_q;
    end

    if (clr_i) begin
      exec_d = '0;
    end else if (inc_i && (exec_q != '1)) begin
      exec_d = exec_q + ONE;
    end else begin
      exec_d = exec_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q <= '0;
      exec_q <= '0;
    end else begin
      step_q <= step_d;
      exec_q <= exec_d;
    end
  end

  assign step_last_o = (step_q == ONE);
  assign exec_cnt_o  = exec_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Debug run controller: boot hold, run/halt/single-step and breakpoint stop of a CPU.
// Breakpoints are built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W      = 4,
  parameter int CNT_W     = 8,
  parameter int BOOT_HOLD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [PC_W-1:0]  pc,
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic             cpu_reset_n,
  output logic             step_done,
  output logic             bp_hit,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] exec_cnt
);

  localparam int BH_W = (BOOT_HOLD < 2) ? 1 : $clog2(BOOT_HOLD + 1);
  localparam logic [BH_W-1:0] BOOT_LOAD = BH_W'(BOOT_HOLD);

  state_e          state_q, state_d;
  logic [BH_W-1:0] boot_q, boot_d;
  logic            en_q, en_d, rstn_q, rstn_d, ready_q, ready_d;
  logic            step_done_q, step_done_d, bp_hit_q, bp_hit_d;
  logic            skip_q, skip_d;
  logic            accept_s, bp_stop_s, cpu_en_s;
  logic            step_load_s, cmd_clr_s, step_last_s;
  cmd_e            cmd_s;

  assign accept_s = cmd_valid && ready_q;
  assign cmd_s    = cmd_e'(cmd);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  // Match is masked for one enabled cycle after BREAK so the stopped instruction can run.
  assign bp_stop_s = bp_valid && (pc == bp_addr) && is_exec(state_q) && !skip_q;
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_valid, bp_addr, pc, skip_q};
  assign bp_stop_s   = 1'b0;
`endif

  assign cpu_en_s = en_q && !bp_stop_s;

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      boot_q      <= BOOT_LOAD;
      en_q        <= 1'b0;
      rstn_q      <= 1'b0;
      ready_q     <= 1'b0;
      step_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      en_q        <= en_d;
      rstn_q      <= rstn_d;
      ready_q     <= ready_d;
      step_done_q <= step_done_d;
      bp_hit_q    <= bp_hit_d;
      skip_q      <= skip_d;
    end
  end

  // Next state; in RUN a RESET command beats a breakpoint, which beats HALT.
  always_comb begin
    state_d     = state_q;
    step_load_s = 1'b0;
    cmd_clr_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_q <= BH_W'(1)) state_d = ST_HALT;
        else                    state_d = ST_BOOT;
      end
      ST_HALT, ST_BREAK: begin
        if (accept_s) begin
          case (cmd_s)
            CMD_RESET: begin state_d = ST_BOOT; cmd_clr_s = 1'b1; end
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP:  begin state_d = ST_STEP; step_load_s = 1'b1; end
            default:   state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (accept_s && (cmd_s == CMD_RESET)) begin
          state_d   = ST_BOOT;
          cmd_clr_s = 1'b1;
        end else if (bp_stop_s) begin
          state_d = ST_BREAK;
        end else if (accept_s && (cmd_s == CMD_HALT)) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (bp_stop_s)        state_d = ST_BREAK;
        else if (step_last_s) state_d = ST_HALT;
        else                  state_d = ST_STEP;
      end
      default: state_d = ST_BOOT;
    endcase

    if ((state_d == ST_BOOT) && (state_q != ST_BOOT)) begin
      boot_d = BOOT_LOAD;
    end else if ((state_q == ST_BOOT) && (boot_q != '0)) begin
      boot_d = boot_q - BH_W'(1);
    end else begin
      boot_d = boot_q;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    en_d        = is_exec(state_d);
    rstn_d      = (state_d != ST_BOOT);
    ready_d     = (state_d == ST_HALT) || (state_d == ST_RUN) || (state_d == ST_BREAK);
    step_done_d = (state_q == ST_STEP) && (state_d == ST_HALT);
    bp_hit_d    = (state_d == ST_BREAK) && (state_q != ST_BREAK);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    if (state_d == ST_BOOT) begin
      skip_d = 1'b0;
    end else if ((state_q == ST_BREAK) && is_exec(state_d)) begin
      skip_d = 1'b1;
    end else if (cpu_en_s) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end
`else
    skip_d = 1'b0;
`endif
  end

  run_ctrl_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_i       (cmd_clr_s),
    .load_i      (step_load_s),
    .load_val_i  (cmd_arg),
    .dec_i       (cpu_en_s && (state_q == ST_STEP)),
    .inc_i       (cpu_en_s),
    .step_last_o (step_last_s),
    .exec_cnt_o  (exec_cnt)
  );

  assign cpu_en      = cpu_en_s;
  assign cpu_reset_n = rstn_q;
  assign cmd_ready   = ready_q;
  assign step_done   = step_done_q;
  assign bp_hit      = bp_hit_q;
  assign state       = state_q;

endmodule
